// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the two-channel round-robin dispatcher.
package dmux_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Preferred channel if its holding register is empty, otherwise the other one.
    function automatic logic pick_target(input logic ptr, input logic full0, input logic full1);
        logic pref_full;
        pref_full = (ptr == CH0) ? full0 : full1;
        return pref_full ? ~ptr : ptr;
    endfunction

endpackage : dmux_pkg

// File: rtl/dmux_hold_reg.sv
// One-entry output holding register with load/drain control and a full flag.
// Data stays stable while full; a load only ever arrives when the entry is empty.
module dmux_hold_reg
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Capture on load, release on drain; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule : dmux_hold_reg

// File: rtl/dmux_dispatch_ctrl.sv
// Round-robin 1x2 demux dispatcher: steers each accepted input beat to one of two
// registered output channels, alternating, with fallback to the free channel.
// Optional per-channel delivered-beat counters are enabled by DMUX_BEAT_CNT_EN.
module dmux_dispatch_ctrl
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
`ifdef DMUX_BEAT_CNT_EN
    , parameter int unsigned CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             y0_valid,
    output logic [WIDTH-1:0] y0_data,
    input  logic             y0_ready,
    output logic             y1_valid,
    output logic [WIDTH-1:0] y1_data,
    input  logic             y1_ready,
    output logic             sel
`ifdef DMUX_BEAT_CNT_EN
    , output logic [CNT_W-1:0] cnt0
    , output logic [CNT_W-1:0] cnt1
`endif
);

    logic r_ptr;
    logic r_sel;

    logic w_full0;
    logic w_full1;
    logic w_accept;
    logic w_tgt;
    logic w_load0;
    logic w_load1;
    logic w_drain0;
    logic w_drain1;

    // Ready depends only on registered full flags, never on downstream ready.
    assign in_ready = ~w_full0 | ~w_full1;
    assign w_accept = in_valid & in_ready;
    assign w_tgt    = pick_target(r_ptr, w_full0, w_full1);
    assign w_load0  = w_accept & (w_tgt == CH0);
    assign w_load1  = w_accept & (w_tgt == CH1);
    assign w_drain0 = w_full0 & y0_ready;
    assign w_drain1 = w_full1 & y1_ready;

    dmux_hold_reg #(.WIDTH(WIDTH)) u_hold0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load0),
        .i_drain (w_drain0),
        .i_data  (in_data),
        .o_full  (w_full0),
        .o_data  (y0_data)
    );

    dmux_hold_reg #(.WIDTH(WIDTH)) u_hold1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load1),
        .i_drain (w_drain1),
        .i_data  (in_data),
        .o_full  (w_full1),
        .o_data  (y1_data)
    );

    // Pointer advances past the channel just loaded; select records that channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= CH0;
            r_sel <= CH0;
        end else if (w_accept) begin
            r_ptr <= ~w_tgt;
            r_sel <= w_tgt;
        end
    end

    assign y0_valid = w_full0;
    assign y1_valid = w_full1;
    assign sel      = r_sel;

`ifdef DMUX_BEAT_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Count completed output handshakes per channel; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_drain0) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_drain1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule : dmux_dispatch_ctrl

// File: tb/tb_dmux_dispatch_ctrl.sv
// Directed self-checking bench for dmux_dispatch_ctrl.
// Define DMUX_BEAT_CNT_EN to also exercise the beat counters (CNT_W = 4).
module tb_dmux_dispatch_ctrl;

    localparam int unsigned WIDTH = 8;
`ifdef DMUX_BEAT_CNT_EN
    localparam int unsigned CNT_W = 4;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             y0_valid;
    logic [WIDTH-1:0] y0_data;
    logic             y0_ready;
    logic             y1_valid;
    logic [WIDTH-1:0] y1_data;
    logic             y1_ready;
    logic             sel;
`ifdef DMUX_BEAT_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dmux_dispatch_ctrl #(
        .WIDTH (WIDTH)
`ifdef DMUX_BEAT_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .y0_valid (y0_valid),
        .y0_data  (y0_data),
        .y0_ready (y0_ready),
        .y1_valid (y1_valid),
        .y1_data  (y1_data),
        .y1_ready (y1_ready),
        .sel      (sel)
`ifdef DMUX_BEAT_CNT_EN
        , .cnt0   (cnt0)
        , .cnt1   (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge to sample/drive.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        @(negedge clk);

        // Reset held 2 cycles with in_valid high
        step();
        step();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("rst_y1_valid", 32'(y1_valid), 32'd0);
        check_eq("rst_sel",      32'(sel),      32'd0);
        check_eq("rst_y0_data",  32'(y0_data),  32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
        check_eq("post_rst_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("post_rst_y1_valid", 32'(y1_valid), 32'd0);

        // Alternation with both consumers ready
        in_valid = 1'b1;
        in_data = 8'hA1; step();
        check_eq("alt1_y0_valid", 32'(y0_valid), 32'd1);
        check_eq("alt1_y0_data",  32'(y0_data),  32'hA1);
        check_eq("alt1_sel",      32'(sel),      32'd0);
        in_data = 8'hA2; step();
        check_eq("alt2_y1_valid", 32'(y1_valid), 32'd1);
        check_eq("alt2_y1_data",  32'(y1_data),  32'hA2);
        check_eq("alt2_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("alt2_sel",      32'(sel),      32'd1);
        in_data = 8'hA3; step();
        check_eq("alt3_y0_data",  32'(y0_data),  32'hA3);
        check_eq("alt3_y1_valid", 32'(y1_valid), 32'd0);
        check_eq("alt3_sel",      32'(sel),      32'd0);
        in_data = 8'hA4; step();
        check_eq("alt4_y1_data",  32'(y1_data),  32'hA4);
        check_eq("alt4_sel",      32'(sel),      32'd1);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        step();
        check_eq("alt_end_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("alt_end_y1_valid", 32'(y1_valid), 32'd0);
        check_eq("alt_end_sel_hold", 32'(sel),      32'd1);

        // Fallback: ch0 stalled, ch1 draining
        y0_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h10; step();
        check_eq("fb1_y0_data", 32'(y0_data), 32'h10);
        check_eq("fb1_sel",     32'(sel),     32'd0);
        in_data = 8'h20; step();
        check_eq("fb2_y1_data",  32'(y1_data),  32'h20);
        check_eq("fb2_y0_hold",  32'(y0_data),  32'h10);
        check_eq("fb2_in_ready", 32'(in_ready), 32'd0);
        in_data = 8'h30; step();
        check_eq("fb3_y1_drained", 32'(y1_valid), 32'd0);
        check_eq("fb3_in_ready",   32'(in_ready), 32'd1);
        check_eq("fb3_y0_valid",   32'(y0_valid), 32'd1);
        step();
        check_eq("fb4_y1_valid", 32'(y1_valid), 32'd1);
        check_eq("fb4_y1_data",  32'(y1_data),  32'h30);
        check_eq("fb4_sel",      32'(sel),      32'd1);
        check_eq("fb4_y0_hold",  32'(y0_data),  32'h10);
        in_valid = 1'b0;
        y0_ready = 1'b1;
        step();
        check_eq("fb_end_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("fb_end_y1_valid", 32'(y1_valid), 32'd0);

        // Full stall with both consumers stalled
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hB1; step();
        check_eq("st1_in_ready", 32'(in_ready), 32'd1);
        in_data = 8'hB2; step();
        check_eq("st2_in_ready", 32'(in_ready), 32'd0);
        in_data = 8'hB3; step();
        check_eq("st3_in_ready", 32'(in_ready), 32'd0);
        check_eq("st3_y0_data",  32'(y0_data),  32'hB1);
        check_eq("st3_y1_data",  32'(y1_data),  32'hB2);
        check_eq("st3_sel",      32'(sel),      32'd1);
        y1_ready = 1'b1; step();
        y1_ready = 1'b0;
        check_eq("st4_in_ready", 32'(in_ready), 32'd1);
        check_eq("st4_y1_valid", 32'(y1_valid), 32'd0);
        step();
        check_eq("st5_y1_valid", 32'(y1_valid), 32'd1);
        check_eq("st5_y1_data",  32'(y1_data),  32'hB3);
        check_eq("st5_y0_data",  32'(y0_data),  32'hB1);
        check_eq("st5_sel",      32'(sel),      32'd1);
        in_valid = 1'b0;

        // Drain ch0 and refill it so ptr points at ch1 before reset
        y0_ready = 1'b1; step();
        y0_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hC1; step();
        check_eq("pre_rst_y0_data", 32'(y0_data), 32'hC1);
        check_eq("pre_rst_full",    32'(in_ready), 32'd0);

        // Reset mid-operation with both consumers ready
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        rst_n    = 1'b0;
        in_data  = 8'hD0;
        step();
        check_eq("mrst_y0_valid", 32'(y0_valid), 32'd0);
        check_eq("mrst_y1_valid", 32'(y1_valid), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mrst_sel",      32'(sel),      32'd0);
`ifdef DMUX_BEAT_CNT_EN
        check_eq("mrst_cnt0", 32'(cnt0), 32'd0);
        check_eq("mrst_cnt1", 32'(cnt1), 32'd0);
`endif
        // First beat after reset must target ch0 (ptr cleared)
        rst_n    = 1'b1;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        in_data  = 8'hE1;
        step();
        check_eq("mrst_ptr_y0_valid", 32'(y0_valid), 32'd1);
        check_eq("mrst_ptr_y0_data",  32'(y0_data),  32'hE1);
        check_eq("mrst_ptr_y1_valid", 32'(y1_valid), 32'd0);
        in_valid = 1'b0;
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        step();

`ifdef DMUX_BEAT_CNT_EN
        // Counter wrap: y1 stalled, beats streamed; drains on ch0 at every even edge
        rst_n = 1'b0; step();
        rst_n    = 1'b1;
        y0_ready = 1'b1;
        y1_ready = 1'b0;
        in_valid = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            in_data = 8'(e);
            step();
            if (e == 2)  check_eq("cnt_e2_cnt0",  32'(cnt0), 32'd1);
            if (e == 30) check_eq("cnt_e30_cnt0", 32'(cnt0), 32'd15);
            if (e == 32) check_eq("cnt_e32_wrap", 32'(cnt0), 32'd0);
        end
        in_valid = 1'b0;
        check_eq("cnt_final_cnt0", 32'(cnt0), 32'd1);
        check_eq("cnt_final_cnt1", 32'(cnt1), 32'd0);
        y1_ready = 1'b1; step();
        check_eq("cnt_ch1_cnt1", 32'(cnt1), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dmux_dispatch_ctrl

// File: doc/dmux_dispatch_ctrl.md
# dmux_dispatch_ctrl

Round-robin dispatcher that sequences the 1x2 demultiplexer datapath. It accepts a valid/ready input stream and steers each accepted beat to one of two output channels, alternating between them. When the preferred channel is busy, it falls back to the other channel. Each channel has a one-entry holding register, so every output is registered. The block sits in front of two downstream consumers and generates the select that the demux datapath uses.

## Interface
Parameters:
- `WIDTH`, default 8: data width of the input and both outputs.
- `CNT_W`, default 16: width of the per-channel beat counters (only present with `DMUX_BEAT_CNT_EN`).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset. **Synchronous, active-low.**
- `in_valid`, input, 1: input beat present.
- `in_data`, input, WIDTH: input payload.
- `in_ready`, output, 1: dispatcher can accept a beat this cycle.
- `y0_valid`, output, 1: channel 0 holding register full.
- `y0_data`, output, WIDTH: channel 0 payload.
- `y0_ready`, input, 1: channel 0 consumer accepts.
- `y1_valid`, output, 1: channel 1 holding register full.
- `y1_data`, output, WIDTH: channel 1 payload.
- `y1_ready`, input, 1: channel 1 consumer accepts.
- `sel`, output, 1: channel that received the most recent accepted beat.
- `cnt0`, output, CNT_W: beats delivered on channel 0 (`DMUX_BEAT_CNT_EN` only).
- `cnt1`, output, CNT_W: beats delivered on channel 1 (`DMUX_BEAT_CNT_EN` only).

## Operation
State:
- `full0` and `full1`: one per holding register.
- `ptr`: the preferred next channel.
- `sel`.

Reset (`rst_n`=0 at a rising edge):
- `full0`, `full1`, `ptr`, `sel` = 0.
- `y0_data`, `y1_data` = 0.
- `cnt0`, `cnt1` = 0.
- Result: `in_ready`=1, `y0_valid`=`y1_valid`=0.
- A reset asserted mid-transfer discards any held beats. No output handshake completes in that cycle.

Ready and valid:
- `in_ready` = `!full0 | !full1`, computed from registered state only. There is no combinational path from `y*_ready` to `in_ready`.
- `y0_valid` = `full0`; `y1_valid` = `full1`.

Target choice on accept (`in_valid & in_ready`):
- `tgt` = `ptr` if `!full[ptr]`, else `~ptr`.
- Load `in_data` into holding register `tgt` and set `full[tgt]`.
- Update `ptr` ← `~tgt` and `sel` ← `tgt`.

Drain:
- `y*_valid & y*_ready` clears that channel's `full` at the clock edge.
- A channel is only loaded when it is empty, so load and drain never coincide on the same channel.
- Load to one channel and drain of the other in the same cycle are independent and both take effect.

Other rules:
- With no accept, `ptr` and `sel` hold.
- Holding-register data is stable while its `valid` is high (AXI-style hold).
- `in_data` is ignored when `in_valid`=0.

## Timing
- Latency: a beat accepted at edge N is presented on its `y*_valid`/`y*_data` at edge N (registered output), so it is visible in cycle N+1.
- Throughput: 1 beat/cycle aggregate while channels alternate and both consumers keep `ready`=1. A single channel alone sustains 1 beat per 2 cycles.
- Backpressure: if both channels are full, `in_ready`=0 until at least one drain edge. `in_ready` rises in the cycle after that drain.
- When both channels are empty, the beat goes to `ptr`.

## Configuration
Macro: `DMUX_BEAT_CNT_EN`.

With the macro defined:
- `cnt0` and `cnt1` exist.
- Each increments by 1 on every completed output handshake of its channel.
- Each wraps from 2^CNT_W−1 to 0.
- Both clear on reset.

Without the macro:
- The ports and counters are absent.
- All other behaviour is identical.

## Structure
Shared package `dmux_pkg`:
- Channel index constants `CH0`=1'b0, `CH1`=1'b1.
- Default `WIDTH`, default `CNT_W`.

Sub-module `dmux_hold_reg`, instantiated twice:
- A one-entry register with `load`, `drain` and `full` flag.
- The top level holds only the pointer/select logic and the counters.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `in_ready`=1, both `y*_valid`=0, `sel`=0; after release, nothing is captured from the reset cycles.
2. Alternation: both `y*_ready`=1; send beats 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → y0 receives 0xA1, 0xA3 and y1 receives 0xA2, 0xA4; `sel` follows 0,1,0,1.
3. Fallback: `y0_ready`=0, `y1_ready`=1; send 0x10, 0x20, 0x30 → 0x10 goes to y0 and holds there; 0x20 goes to y1; after y1 drains, 0x30 goes to y1 because ch0 is still full.
4. Full stall: both `y*_ready`=0; send 3 beats → `in_ready`=0 after the 2nd accept, and the 3rd beat waits; raise `y1_ready` for one cycle → the 3rd beat is accepted into y1 one cycle later.
5. Reset mid-operation: both channels full, assert `rst_n`=0 → next cycle both `y*_valid`=0, `ptr`=0, and no handshakes are counted.
6. With `DMUX_BEAT_CNT_EN`, `CNT_W`=4: 17 drains on y0 → `cnt0`=1 (wrapped) and `cnt1`=0.
